// File: rtl/systolic_row_drain.sv
// systolic_row_drain
//   Sits at the output end of a systolic row. Captures one row of PE
//   accumulator results in a single-cycle handshake. It then streams the
//   results out one word per cycle. Each word is sign-extended to OUT_WIDTH
//   and tagged with its column and its row-within-tile.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid     : result bus valid
//   in_ready     : drain can capture in_b_bus this cycle
//   in_b_bus     : packed PE results, word j at [OUTPUT_DATA_WIDTH*j +: OUTPUT_DATA_WIDTH]
//   in_last      : captured row is the last row of the current tile
//   out_valid    : out_data valid
//   out_ready    : downstream accepts out_data
//   out_data     : sign-extended result word
//   out_col      : PE index of out_data
//   out_row      : row index within the tile
//   out_last     : final word of the final row of the tile
//   busy         : a row is held or being streamed
//
// Handshake rule, both sides: a transfer happens on a rising edge where
// valid && ready. Once out_valid is high, it stays high and all out_*
// fields stay stable until the transfer happens.
module systolic_row_drain #(
  parameter int PE_NUM            = 16,
  parameter int OUTPUT_DATA_WIDTH = 24,
  parameter int OUT_WIDTH         = 32,
  parameter int ROW_CNT_WIDTH     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [OUTPUT_DATA_WIDTH*PE_NUM-1:0] in_b_bus,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic [$clog2(PE_NUM)-1:0]           out_col,
  output logic [ROW_CNT_WIDTH-1:0]            out_row,
  output logic                                out_last,
  output logic                                busy
);

  localparam int COL_W = $clog2(PE_NUM);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(PE_NUM - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                         state;
  logic [COL_W-1:0]               col;
  logic [ROW_CNT_WIDTH-1:0]       row;
  logic                           last_q;
  logic [OUTPUT_DATA_WIDTH-1:0]   shadow [PE_NUM];

  logic at_last_col;
  logic word_xfer;
  logic capture;

  assign at_last_col = (col == LAST_COL);
  assign out_valid   = (state == STREAM);
  assign busy        = (state == STREAM);
  assign word_xfer   = out_valid && out_ready;
  // A new row may be captured in the same cycle the final word of the
  // held row leaves. This gives back-to-back rows with no bubble.
  assign in_ready    = (state == IDLE) || (at_last_col && out_ready);
  assign capture     = in_valid && in_ready;

  assign out_data = OUT_WIDTH'($signed(shadow[col]));
  assign out_col  = col;
  assign out_row  = row;
  assign out_last = (state == STREAM) && at_last_col && last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      col    <= '0;
      row    <= '0;
      last_q <= 1'b0;
      for (int j = 0; j < PE_NUM; j++) shadow[j] <= '0;
    end else begin
      if (word_xfer) begin
        if (!at_last_col) begin
          col <= col + 1'b1;
        end else begin
          // Row complete. The tile-end restart takes priority over increment.
          row   <= last_q ? '0 : row + 1'b1;
          state <= IDLE;
        end
      end
      // A capture overrides the IDLE return above when both happen together.
      if (capture) begin
        for (int j = 0; j < PE_NUM; j++)
          shadow[j] <= in_b_bus[OUTPUT_DATA_WIDTH*j +: OUTPUT_DATA_WIDTH];
        last_q <= in_last;
        col    <= '0;
        state  <= STREAM;
      end
    end
  end

endmodule

// File: doc/systolic_row_drain.md
Name: systolic_row_drain

Overview:
- Consumer at the output end of a systolic row.
- Captures one row's worth of PE accumulator results (a PE_NUM x OUTPUT_DATA_WIDTH packed bus) in a single-cycle handshake.
- Streams the results out one word per cycle on a valid/ready interface, sign-extended to the output word width, with row and column tags.
- Sits between the array's result bus and the writeback/DMA path; converts a wide parallel drain into a narrow serial stream.

Parameters:
- PE_NUM, 16, number of PEs per row (number of words per captured bus); must be >= 2.
- OUTPUT_DATA_WIDTH, 24, width of each PE result (signed two's complement).
- OUT_WIDTH, 32, width of each streamed word; must be >= OUTPUT_DATA_WIDTH.
- ROW_CNT_WIDTH, 8, width of the row tag counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  result bus valid.
- in_ready  output  1  drain can capture in_b_bus this cycle.
- in_b_bus  input  OUTPUT_DATA_WIDTH*PE_NUM  packed results; word j at bits [OUTPUT_DATA_WIDTH*j +: OUTPUT_DATA_WIDTH].
- in_last  input  1  captured row is the last row of the current tile.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  OUT_WIDTH  sign-extended result word.
- out_col  output  $clog2(PE_NUM)  PE index of out_data.
- out_row  output  ROW_CNT_WIDTH  row index within the tile.
- out_last  output  1  final word of the final row of the tile.
- busy  output  1  high while a row is held or being streamed.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_col=0, out_row=0, out_last=0, busy=0. The shadow buffer is cleared to 0.
- Reset mid-stream discards the held row immediately; no partial words are emitted after rst deasserts.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - STREAM: out_valid=1. out_data = sign-extended shadow[col]; out_col = col.
- Capture: in_valid && in_ready at edge N.
  - in_b_bus and in_last are latched into the shadow buffer.
  - col <= 0; state <= STREAM.
  - out_valid rises at cycle N+1 (latency 1).
- Word transfer occurs on out_valid && out_ready. Then:
  - If col < PE_NUM-1: col <= col+1.
  - Else (final word): the row completes.
- out_data, out_col, out_row, out_last are held stable while out_valid && !out_ready (AXI-style). out_valid never drops without a transfer.
- in_ready in STREAM is 1 only when col == PE_NUM-1 && out_ready. This allows a back-to-back capture with zero bubbles: in that cycle the final word transfers and the new bus is captured; next cycle state stays STREAM with col=0.
- Row completion:
  - If no capture occurs in the same cycle, state <= IDLE.
  - out_row increments after each completed row.
  - If the completed row had in_last=1, out_row <= 0 instead; this takes priority over increment.
  - out_row wraps modulo 2^ROW_CNT_WIDTH.
- out_last = 1 only when col == PE_NUM-1 and the held row's in_last = 1.
- Arithmetic: out_data = {(OUT_WIDTH-OUTPUT_DATA_WIDTH){w[MSB]}, w}. No saturation or rounding.
- busy = (state == STREAM).
- Throughput: sustained PE_NUM words per PE_NUM cycles with out_ready held at 1.
- in_valid while in_ready=0 is ignored; the upstream must hold the bus until accepted.

Test Plan:
- Reset then single row: word j = j-8 (PE_NUM=16), in_last=0, out_ready=1 -> out_valid rises 1 cycle after capture; 16 words emitted: 0xFFFFFFF8 … 0x00000007; out_col 0..15; out_row=0; out_last=0; returns to IDLE; next row tagged out_row=1.
- Back-pressure: toggle out_ready 1,0,0,1 repeatedly -> out_data/out_col stable during stalls; all 16 words emitted exactly once, in order; in_ready stays 0 until the final-word transfer.
- Back-to-back: in_valid held high with rows A (all 0x000001) and B (all 0x800000), out_ready=1 -> 32 consecutive valid cycles with no bubble; B words appear as 0xFF800000; row B tagged out_row = A's row + 1.
- Tile end: three rows with in_last = 0,0,1 -> out_last asserts only on the 48th word (row 2, col 15); the following row is tagged out_row=0.
- Reset mid-stream: assert rst at col=5 -> out_valid=0 and in_ready=1 asynchronously; after release, no residual words; a new row starts at col=0, row=0.
- Row counter wrap with ROW_CNT_WIDTH=2: five rows, in_last=0 -> out_row sequence 0,1,2,3,0.
